dps_utim_nch: RTL and testbench
===============================

Name: dps_utim_nch

Overview:
Parametrised next-generation universal timer for the default peripheral system. It provides one free-running main counter of configurable width with a programmable prescaler, and NUM_CC compare channels. Each channel runs in one-shot or periodic mode and has its own interrupt enable. It sits behind the DPS register request bus and raises an interrupt with a channel number, held until acknowledged.

Parameters:
CNT_W, 64, main counter and compare width (legal range 16..64).
NUM_CC, 4, number of compare channels (legal range 1..8).
PRE_W, 8, prescaler width (legal range 1..16).

Ports:
iCLOCK  in  1  system clock
inRESET  in  1  asynchronous active-low reset
iREQ  in  1  register request strobe, one cycle per request
oBUSY  out  1  request not accepted this cycle
iRW  in  1  1 = write, 0 = read
iADDR  in  8  byte address (word aligned, bits[1:0] ignored)
iDATA  in  32  write data
oVALID  out  1  read data valid
oDATA  out  32  read data
oIRQ_REQ  out  1  interrupt request
oIRQ_NUM  out  3  channel number of the current request
iIRQ_ACK  in  1  interrupt acknowledge

Behaviour:
- Reset (async, inRESET=0): all registers, flags, pending bits and the counter clear. oBUSY=0, oVALID=0, oDATA=0, oIRQ_REQ=0, oIRQ_NUM=0. Reset mid-operation aborts any read in flight; no oVALID follows.
- Register map (unmapped read returns 0, unmapped write is ignored):
  - 0x00 MCFG: bit0 counter enable; bits[8+PRE_W-1:8] prescale value PSC.
  - 0x04 MC_HI, 0x08 MC_LO. Reading MC_LO returns the low word and snapshots the high word into a shadow register; MC_HI reads return the shadow. Writing MC_HI loads a write shadow; writing MC_LO commits {shadow, data} to the counter. Bits above CNT_W are read as 0 and dropped on write.
  - Channel n (n < NUM_CC) has base 0x20 + 0x10*n:
    - +0x0 CCR_HI, +0x4 CCR_LO: period/offset, read and written directly.
    - +0x8 CCCFG: bit0 enable, bit1 irq enable, bit2 mode (1 periodic, 0 one-shot).
    - +0xC STAT: bit0 match flag, bit1 irq pending. Writing 1 to a bit clears it.
- Prescaler: counts while enabled. A tick occurs when the prescaler equals PSC, and the prescaler then returns to 0. PSC=0 gives a tick every cycle. Clearing the counter enable resets the prescaler.
- Counter: increments by 1 per tick, modulo 2^CNT_W (all-ones wraps to 0). A commit to MC_LO in the same cycle as a tick wins, and the tick is lost.
- Channel arm: when a CCCFG write changes enable from 0 to 1, TARGET <= counter + CCR mod 2^CNT_W.
- Match: evaluated on each tick with an enabled channel, when the new counter value == TARGET.
  - On match: match flag is set. If irq enable is set, pending is set.
  - Periodic mode: TARGET <= TARGET + CCR mod 2^CNT_W.
  - One-shot mode: enable clears.
  - A CCCFG write in the same cycle as a match: the written enable value wins, and the flag/pending bits still set.
- IRQ:
  - When oIRQ_REQ=0 and any pending bit is set: the next cycle oIRQ_REQ=1 and oIRQ_NUM = lowest pending index.
  - oIRQ_REQ and oIRQ_NUM are held stable until iIRQ_ACK.
  - On ack: that channel's pending bit clears, and oIRQ_REQ=0 for at least one cycle.
  - If a new match on the same channel coincides with the ack, pending remains set.
  - iIRQ_ACK while oIRQ_REQ=0 is ignored.
- Bus:
  - Writes take effect at the clock edge of the request.
  - Reads return oVALID=1 with oDATA exactly one cycle after the request; oDATA=0 when oVALID=0.
  - oBUSY=1 in the cycle following a read request. A request presented while oBUSY=1 is ignored.
  - Back-to-back writes are accepted every cycle.

Test Plan:
- Reset: hold inRESET=0, then release. All outputs are 0. Reading 0x08 -> oVALID one cycle later with oDATA=0. Reading 0x04 -> 0.
- Prescale: write MCFG=0x00000301 (PSC=3, enable), run 40 cycles, disable, read MC_LO -> 10.
- Periodic IRQ: PSC=0; ch0 CCR_LO=0x10, CCCFG=0x7; counter enabled. oIRQ_REQ=1 with NUM=0 every 16 ticks. Ack -> REQ drops, STAT0 reads 0x1. Write STAT0=1 -> reads 0.
- One-shot: ch1 CCR_LO=5, CCCFG=0x3. Exactly one IRQ with NUM=1. CCCFG then reads 0x2, and no further match occurs after 100 cycles.
- Priority: ch0 and ch2 armed to match on the same tick, both irq-enabled. First request NUM=0; after ack, next request NUM=2; after ack, oIRQ_REQ stays 0.
- Wrap: CNT_W=64. Write MC_HI=0xFFFFFFFF, MC_LO=0xFFFFFFFE; arm ch0 one-shot CCR=3. Counter reads 0 after 2 ticks and the match occurs at counter=1. Then assert inRESET mid-read -> no oVALID and all state clears.

Source files
------------

// File: rtl/dps_utim_nch.sv
// Universal timer: prescaled free-running counter plus NUM_CC compare channels
// behind the DPS register bus, with one held interrupt that carries a channel number.

module dps_utim_nch_ch #(
  parameter int CNT_W = 64
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             step,      // counter advances to cnt_nxt at this edge
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] cnt_nxt,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic             wr_cfg,
  input  logic             wr_stat,
  input  logic [31:0]      wdata,
  input  logic             ack_clr,
  output logic [CNT_W-1:0] ccr,
  output logic [2:0]       cfg,
  output logic [1:0]       stat
);
  logic [CNT_W-1:0] target;
  logic [63:0]      ccr_ext;
  logic             en, ie, mode, flag, pend, match;

  assign ccr_ext = 64'(ccr);
  assign match   = step && en && (cnt_nxt == target);
  assign cfg     = {mode, ie, en};
  assign stat    = {pend, flag};

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      ccr    <= '0;
      target <= '0;
      en     <= 1'b0;
      ie     <= 1'b0;
      mode   <= 1'b0;
      flag   <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (wr_hi) ccr <= CNT_W'({wdata, ccr_ext[31:0]});
      if (wr_lo) ccr <= CNT_W'({ccr_ext[63:32], wdata});
      if (match && mode) target <= target + ccr;
      // a config write overrides the one-shot auto-disable; arming uses the pre-edge counter
      if (wr_cfg) begin
        if (wdata[0] && !en) target <= cnt + ccr;
        en   <= wdata[0];
        ie   <= wdata[1];
        mode <= wdata[2];
      end else if (match && !mode) begin
        en <= 1'b0;
      end
      flag <= (flag && !(wr_stat && wdata[0])) || match;
      pend <= (pend && !(wr_stat && wdata[1]) && !ack_clr) || (match && ie);
    end
  end
endmodule

module dps_utim_nch #(
  parameter int CNT_W  = 64,
  parameter int NUM_CC = 4,
  parameter int PRE_W  = 8
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ,
  output logic        oBUSY,
  input  logic        iRW,
  input  logic [7:0]  iADDR,
  input  logic [31:0] iDATA,
  output logic        oVALID,
  output logic [31:0] oDATA,
  output logic        oIRQ_REQ,
  output logic [2:0]  oIRQ_NUM,
  input  logic        iIRQ_ACK
);
  typedef enum logic {IRQ_IDLE, IRQ_HOLD} irq_state_t;

  logic                          busy, acc, wr, rd;
  logic [3:0]                    blk;
  logic [1:0]                    sel;
  logic                          cnt_en, tick, commit, step;
  logic [PRE_W-1:0]              psc, pre;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic [63:0]                   cnt_ext;
  logic [31:0]                   wsh, rsh, rdata;
  logic [NUM_CC-1:0][CNT_W-1:0]  ccr;
  logic [NUM_CC-1:0][63:0]       ccr_ext;
  logic [NUM_CC-1:0][2:0]        cfg;
  logic [NUM_CC-1:0][1:0]        stat;
  logic [NUM_CC-1:0]             pend, ack_clr;
  irq_state_t                    irq_q, irq_d;
  logic [2:0]                    num_q, num_d, low_idx;
  logic                          unused_addr;

  assign acc         = iREQ && !busy;
  assign wr          = acc && iRW;
  assign rd          = acc && !iRW;
  assign blk         = iADDR[7:4];
  assign sel         = iADDR[3:2];
  assign unused_addr = ^iADDR[1:0];

  assign tick    = cnt_en && (pre == psc);
  assign commit  = wr && (blk == 4'h0) && (sel == 2'd2);
  assign step    = tick && !commit;  // a counter commit swallows the tick
  assign cnt_nxt = cnt + CNT_W'(1);
  assign cnt_ext = 64'(cnt);

  assign oBUSY    = busy;
  assign oIRQ_REQ = (irq_q == IRQ_HOLD);
  assign oIRQ_NUM = num_q;

  always_comb begin
    rdata = '0;
    if (blk == 4'h0) begin
      case (sel)
        2'd0: begin
          rdata[0]          = cnt_en;
          rdata[8 +: PRE_W] = psc;
        end
        2'd1:    rdata = rsh;
        2'd2:    rdata = cnt_ext[31:0];
        default: rdata = '0;
      endcase
    end
    for (int n = 0; n < NUM_CC; n++) begin
      if (blk == 4'(n + 2)) begin
        case (sel)
          2'd0:    rdata = ccr_ext[n][63:32];
          2'd1:    rdata = ccr_ext[n][31:0];
          2'd2:    rdata = 32'(cfg[n]);
          default: rdata = 32'(stat[n]);
        endcase
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      busy   <= 1'b0;
      oVALID <= 1'b0;
      oDATA  <= '0;
      rsh    <= '0;
      wsh    <= '0;
      cnt_en <= 1'b0;
      psc    <= '0;
      pre    <= '0;
      cnt    <= '0;
      irq_q  <= IRQ_IDLE;
      num_q  <= '0;
    end else begin
      busy   <= rd;
      oVALID <= rd;
      oDATA  <= rd ? rdata : '0;
      if (rd && blk == 4'h0 && sel == 2'd2) rsh <= cnt_ext[63:32];
      if (wr && blk == 4'h0 && sel == 2'd1) wsh <= iDATA;
      if (wr && blk == 4'h0 && sel == 2'd0) begin
        cnt_en <= iDATA[0];
        psc    <= iDATA[8 +: PRE_W];
      end
      if (!cnt_en || tick) pre <= '0;
      else                 pre <= pre + PRE_W'(1);
      if (commit)    cnt <= CNT_W'({wsh, iDATA});
      else if (tick) cnt <= cnt_nxt;
      irq_q <= irq_d;
      num_q <= num_d;
    end
  end

  always_comb begin
    low_idx = '0;
    for (int n = NUM_CC - 1; n >= 0; n--) begin
      if (pend[n]) low_idx = 3'(n);
    end
  end

  // interrupt is latched with its channel number and held until acknowledged
  always_comb begin
    irq_d   = irq_q;
    num_d   = num_q;
    ack_clr = '0;
    case (irq_q)
      IRQ_IDLE: begin
        if (|pend) begin
          irq_d = IRQ_HOLD;
          num_d = low_idx;
        end
      end
      IRQ_HOLD: begin
        if (iIRQ_ACK) begin
          irq_d = IRQ_IDLE;
          for (int n = 0; n < NUM_CC; n++) ack_clr[n] = (num_q == 3'(n));
        end
      end
      default: irq_d = IRQ_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CC; g++) begin : g_ch
    logic hit;
    assign hit        = wr && (blk == 4'(g + 2));
    assign ccr_ext[g] = 64'(ccr[g]);
    assign pend[g]    = stat[g][1];

    dps_utim_nch_ch #(.CNT_W(CNT_W)) u_ch (
      .gclk    (iCLOCK),
      .grst_n  (inRESET),
      .step    (step),
      .cnt     (cnt),
      .cnt_nxt (cnt_nxt),
      .wr_hi   (hit && sel == 2'd0),
      .wr_lo   (hit && sel == 2'd1),
      .wr_cfg  (hit && sel == 2'd2),
      .wr_stat (hit && sel == 2'd3),
      .wdata   (iDATA),
      .ack_clr (ack_clr[g]),
      .ccr     (ccr[g]),
      .cfg     (cfg[g]),
      .stat    (stat[g])
    );
  end
endmodule

// File: tb/tb_dps_utim_nch.sv
// Scoreboard bench for dps_utim_nch: a cycle-level reference model predicts
// read data and interrupt events; a monitor pops and compares as the DUT responds.

module tb_dps_utim_nch;
  localparam int NUM_CC = 4;

  logic        iCLOCK = 1'b0, inRESET = 1'b0, iREQ = 1'b0, iRW = 1'b0, iIRQ_ACK = 1'b0;
  logic [7:0]  iADDR = '0;
  logic [31:0] iDATA = '0;
  logic        oBUSY, oVALID, oIRQ_REQ;
  logic [31:0] oDATA;
  logic [2:0]  oIRQ_NUM;

  int checks = 0, failures = 0;

  always #5 iCLOCK = ~iCLOCK;

  dps_utim_nch #(.CNT_W(64), .NUM_CC(NUM_CC), .PRE_W(8)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iREQ(iREQ), .oBUSY(oBUSY), .iRW(iRW),
    .iADDR(iADDR), .iDATA(iDATA), .oVALID(oVALID), .oDATA(oDATA),
    .oIRQ_REQ(oIRQ_REQ), .oIRQ_NUM(oIRQ_NUM), .iIRQ_ACK(iIRQ_ACK)
  );

  // reference model state
  bit              m_en, m_busy, m_irq;
  int unsigned     m_psc;
  longint unsigned m_run;
  logic [63:0]     m_cnt;
  logic [31:0]     m_wsh, m_rsh;
  logic [63:0]     m_ccr [NUM_CC];
  logic [63:0]     m_tgt [NUM_CC];
  bit              m_cen [NUM_CC], m_ie [NUM_CC], m_mode [NUM_CC], m_flag [NUM_CC], m_pend [NUM_CC];
  int              m_num, m_age;
  logic [31:0]     rd_q [$];
  int              irq_q [$];
  bit              irq_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_en = 0; m_busy = 0; m_irq = 0; m_psc = 0; m_run = 0; m_cnt = '0;
    m_wsh = '0; m_rsh = '0; m_num = 0; m_age = 0;
    for (int n = 0; n < NUM_CC; n++) begin
      m_ccr[n] = '0; m_tgt[n] = '0; m_cen[n] = 0; m_ie[n] = 0;
      m_mode[n] = 0; m_flag[n] = 0; m_pend[n] = 0;
    end
    rd_q.delete();
    irq_q.delete();
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int blk, sel, n;
    blk = int'(a[7:4]);
    sel = int'(a[3:2]);
    m_read = '0;
    if (blk == 0) begin
      case (sel)
        0: m_read = {16'd0, 8'(m_psc), 7'd0, m_en};
        1: m_read = m_rsh;
        2: m_read = m_cnt[31:0];
        default: m_read = '0;
      endcase
    end else if (blk >= 2 && blk - 2 < NUM_CC) begin
      n = blk - 2;
      case (sel)
        0: m_read = m_ccr[n][63:32];
        1: m_read = m_ccr[n][31:0];
        2: m_read = {29'd0, m_mode[n], m_ie[n], m_cen[n]};
        default: m_read = {30'd0, m_pend[n], m_flag[n]};
      endcase
    end
  endfunction

  function automatic bit ack_now();
    return m_irq && (m_age >= 2);
  endfunction

  // One bus cycle: drive inputs, advance the model to the post-edge state.
  task automatic cyc(input bit req, input bit rw, input logic [7:0] a, input logic [31:0] d, input bit ack);
    bit acc, wr, rd, tick, commit, adv, wch, old_en, old_ie, old_irq;
    bit match [NUM_CC];
    int blk, sel, low;
    logic [63:0] old_ccr;
    @(negedge iCLOCK);
    iREQ = req; iRW = rw; iADDR = a; iDATA = d; iIRQ_ACK = ack;
    acc = req && !m_busy;
    wr  = acc && rw;
    rd  = acc && !rw;
    blk = int'(a[7:4]);
    sel = int'(a[3:2]);
    if (rd) rd_q.push_back(m_read(a));
    tick   = m_en && ((m_run % (m_psc + 1)) == m_psc);
    commit = wr && blk == 0 && sel == 2;
    adv    = tick && !commit;
    low = -1;
    for (int n = NUM_CC - 1; n >= 0; n--) if (m_pend[n]) low = n;
    old_irq = m_irq;
    for (int n = 0; n < NUM_CC; n++) begin
      match[n] = adv && m_cen[n] && (m_cnt + 64'd1 == m_tgt[n]);
      wch      = wr && blk == n + 2;
      old_en   = m_cen[n];
      old_ie   = m_ie[n];
      old_ccr  = m_ccr[n];
      m_flag[n] = (m_flag[n] && !(wch && sel == 3 && d[0])) || match[n];
      m_pend[n] = (m_pend[n] && !(wch && sel == 3 && d[1]) && !(old_irq && ack && m_num == n))
                  || (match[n] && old_ie);
      if (match[n] && m_mode[n]) m_tgt[n] = m_tgt[n] + old_ccr;
      if (match[n] && !m_mode[n]) m_cen[n] = 0;
      if (wch && sel == 2) begin
        if (d[0] && !old_en) m_tgt[n] = m_cnt + old_ccr;
        m_cen[n] = d[0]; m_ie[n] = d[1]; m_mode[n] = d[2];
      end
      if (wch && sel == 0) m_ccr[n] = {d, old_ccr[31:0]};
      if (wch && sel == 1) m_ccr[n] = {old_ccr[63:32], d};
    end
    if (old_irq && ack) m_irq = 0;
    else if (!old_irq && low >= 0) begin
      m_irq = 1; m_num = low; m_age = 0; irq_q.push_back(low);
    end
    if (old_irq && m_irq) m_age++;
    if (rd && blk == 0 && sel == 2) m_rsh = m_cnt[63:32];
    if (commit)    m_cnt = {m_wsh, d};
    else if (tick) m_cnt = m_cnt + 64'd1;
    if (wr && blk == 0 && sel == 1) m_wsh = d;
    m_run = m_en ? m_run + 1 : 0;
    if (wr && blk == 0 && sel == 0) begin
      m_en = d[0]; m_psc = int'(d[15:8]);
    end
    m_busy = rd;
    @(posedge iCLOCK); #1;
    check("busy", {63'd0, oBUSY}, {63'd0, m_busy});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(1, 1, a, d, ack_now());
  endtask
  task automatic rd(input logic [7:0] a);
    cyc(1, 0, a, 0, ack_now());
    cyc(0, 0, 0, 0, ack_now());
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ack_now());
  endtask

  // monitor: read data and interrupt raises against the scoreboard queues
  always @(negedge iCLOCK) begin
    if (oVALID) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got %0h expected no response", oDATA);
      end else check("rdata", {32'd0, oDATA}, {32'd0, rd_q.pop_front()});
    end else if (oDATA !== 32'd0) check("rdata_idle", {32'd0, oDATA}, 64'd0);
    if (oIRQ_REQ && !irq_prev) begin
      if (irq_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL irq_unexpected: got num %0d expected none", oIRQ_NUM);
      end else check("irq_num", {61'd0, oIRQ_NUM}, 64'(irq_q.pop_front()));
    end
    irq_prev = oIRQ_REQ;
  end

  initial begin
    int psc_r, r, n;
    logic [7:0] a;
    model_reset();
    repeat (3) @(negedge iCLOCK);
    check("rst_busy",  {63'd0, oBUSY},    64'd0);
    check("rst_valid", {63'd0, oVALID},   64'd0);
    check("rst_data",  {32'd0, oDATA},    64'd0);
    check("rst_irq",   {63'd0, oIRQ_REQ}, 64'd0);
    check("rst_num",   {61'd0, oIRQ_NUM}, 64'd0);
    inRESET = 1'b1;
    rd(8'h08);
    rd(8'h04);

    // prescaler PSC=3 for 40 cycles
    wr(8'h00, 32'h301);
    idle(40);
    wr(8'h00, 32'h300);
    rd(8'h08);
    rd(8'h00);

    // periodic channel 0
    wr(8'h04, 0); wr(8'h08, 0);
    wr(8'h24, 32'h10); wr(8'h28, 32'h7);
    wr(8'h00, 32'h1);
    idle(70);
    wr(8'h00, 32'h0);
    idle(4);
    rd(8'h2C);
    wr(8'h2C, 32'h3);
    rd(8'h2C);
    wr(8'h28, 32'h0);

    // one-shot channel 1
    wr(8'h34, 32'h5); wr(8'h38, 32'h3);
    wr(8'h00, 32'h1);
    idle(100);
    wr(8'h00, 32'h0);
    idle(4);
    rd(8'h38);
    rd(8'h3C);

    // channels 0 and 2 matching on the same tick
    wr(8'h24, 32'h8); wr(8'h44, 32'h8);
    wr(8'h28, 32'h3); wr(8'h48, 32'h3);
    wr(8'h00, 32'h1);
    idle(30);
    check("prio_irq_idle", {63'd0, oIRQ_REQ}, {63'd0, m_irq});
    wr(8'h00, 32'h0);

    // 64-bit wrap with a one-shot match at counter=1
    wr(8'h04, 32'hFFFF_FFFF); wr(8'h08, 32'hFFFF_FFFE);
    wr(8'h20, 0); wr(8'h24, 32'h3); wr(8'h28, 32'h3);
    wr(8'h00, 32'h1);
    idle(2);
    rd(8'h08);
    rd(8'h04);
    idle(3);
    wr(8'h00, 32'h0);
    idle(4);
    rd(8'h2C);
    rd(8'h28);

    // randomized traffic
    psc_r = $urandom_range(0, 2);
    wr(8'h00, 32'(psc_r) << 8);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(0, NUM_CC - 1);
      a = 8'($urandom);
      case (r)
        0, 1, 2, 3: cyc(0, 0, 0, 0, ack_now() || ($urandom_range(0, 3) == 0));
        4, 5: rd(a);
        6: begin
          r = $urandom_range(0, 3);
          a = 8'(8'h20 + 16 * n + 4 * r);
          case (r)
            0: wr(a, ($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
            1: wr(a, 32'($urandom_range(1, 40)));
            2: wr(a, 32'($urandom_range(0, 7)));
            default: wr(a, 32'($urandom_range(0, 3)));
          endcase
        end
        7: wr(8'h00, (32'(psc_r) << 8) | 32'($urandom_range(0, 1)));
        8: begin wr(8'h04, 0); wr(8'h08, 32'($urandom_range(0, 200))); end
        default: begin
          cyc(1, 0, a, 0, ack_now());
          cyc(1, $urandom_range(0, 1) == 1, 8'h00, 32'h0, ack_now());
        end
      endcase
    end
    wr(8'h00, 32'h0);
    idle(12);
    check("irq_level", {63'd0, oIRQ_REQ}, {63'd0, m_irq});

    // reset asserted while a read is being requested: no response may follow
    @(negedge iCLOCK);
    iREQ = 1'b1; iRW = 1'b0; iADDR = 8'h08; iIRQ_ACK = 1'b0;
    inRESET = 1'b0;
    model_reset();
    @(posedge iCLOCK); #1;
    check("abort_valid", {63'd0, oVALID}, 64'd0);
    @(negedge iCLOCK);
    iREQ = 1'b0;
    @(negedge iCLOCK);
    check("abort_irq", {63'd0, oIRQ_REQ}, 64'd0);
    check("abort_busy", {63'd0, oBUSY}, 64'd0);
    inRESET = 1'b1;
    rd(8'h08);
    rd(8'h00);
    rd(8'h28);
    rd(8'h2C);
    idle(2);
    check("irq_events_left", 64'(irq_q.size()), 64'd0);
    check("rd_left", 64'(rd_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
